// File: rtl/defuse_pkg.sv
// Shared types and constants for the defuse round engine.
// Covers the FSM state encoding, main-screen rule codes and screen widths.
package defuse_pkg;

    localparam int unsigned SCR_W  = 2;
    localparam int unsigned RIDX_W = 4;
    localparam int unsigned STRK_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RND,
        S_ARMED,
        S_WIN,
        S_LOSS
    } state_t;

    typedef enum logic [1:0] {
        M_LABEL3 = 2'd0,
        M_REPEAT = 2'd1,
        M_FWD    = 2'd2,
        M_REV    = 2'd3
    } main_rule_t;

    // Index width that can address n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/defuse_round_engine_if.sv
// Screen-generator handshake: the engine requests, the generator answers with one valid beat.
interface defuse_round_engine_if #(
    parameter int unsigned N_SW = 4
) ();
    import defuse_pkg::*;

    logic                    rnd_req;
    logic                    rnd_valid;
    logic [SCR_W-1:0]        rnd_main;
    logic [SCR_W*N_SW-1:0]   rnd_subs;

    modport master (
        output rnd_req,
        input  rnd_valid,
        input  rnd_main,
        input  rnd_subs
    );

    modport slave (
        input  rnd_req,
        output rnd_valid,
        output rnd_main,
        output rnd_subs
    );

endinterface

// File: rtl/defuse_rule_lut.sv
// Combinational lookup of the expected answer index for the current round and screens.
module defuse_rule_lut
    import defuse_pkg::*;
#(
    parameter int unsigned N_SW     = 4,
    parameter int unsigned N_ROUNDS = 4,
    parameter int unsigned IW       = idx_w(N_SW)
) (
    input  logic [RIDX_W-1:0]             r,
    input  logic [SCR_W-1:0]              main,
    input  logic [SCR_W*N_SW-1:0]         subs,
    input  logic [N_ROUNDS-1:0][IW-1:0]   history,
    output logic [IW-1:0]                 e_c
);

    logic [IW-1:0] label_idx;
    logic [IW-1:0] prev_idx;
    logic [IW-1:0] rmod;

    always_comb begin
        label_idx = IW'(N_SW - 1);
        prev_idx  = '0;
        rmod      = IW'(int'(r) % int'(N_SW));
        e_c       = '0;

        // Scan downwards so the lowest matching screen wins.
        for (int i = int'(N_SW) - 1; i >= 0; i--) begin
            if (subs[SCR_W*i +: SCR_W] == 2'b11) begin
                label_idx = IW'(i);
            end
        end

        for (int i = 0; i < int'(N_ROUNDS); i++) begin
            if (int'(r) == i + 1) begin
                prev_idx = history[i];
            end
        end

        case (main_rule_t'(main))
            M_LABEL3: e_c = label_idx;
            M_REPEAT: e_c = prev_idx;
            M_FWD:    e_c = rmod;
            M_REV:    e_c = IW'(N_SW - 1) - rmod;
        endcase
    end

endmodule

// File: rtl/defuse_round_engine.sv
// Bomb-defuse round sequencer: fetches screens, judges button presses, tracks
// strikes, per-round timeout and saturating score, and reports win/loss.
module defuse_round_engine
    import defuse_pkg::*;
#(
    parameter int unsigned N_SW        = 4,
    parameter int unsigned N_ROUNDS    = 4,
    parameter int unsigned N_LIVES     = 1,
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned PTS         = 5,
    parameter int unsigned ROUND_TICKS = 30
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Game_Enable,
    input  logic                      button,
    input  logic [N_SW-1:0]           switch_position,
    input  logic                      tick,
    defuse_round_engine_if.master     rnd,
    output logic [SCR_W-1:0]          main_disp,
    output logic [SCR_W*N_SW-1:0]     sub_disp,
    output logic [RIDX_W-1:0]         round_idx,
    output logic [STRK_W-1:0]         strikes,
    output logic [SCORE_W-1:0]        Score,
    output logic                      Game_Complete,
    output logic                      game_won
);

    localparam int unsigned IW  = idx_w(N_SW);
    localparam int unsigned TW  = idx_w(ROUND_TICKS + 1);
    localparam int unsigned SW1 = SCORE_W + 1;

    state_t                      state;
    logic                        btn_q;
    logic                        rearm;
    logic [TW-1:0]               tick_cnt;
    logic [N_ROUNDS-1:0][IW-1:0] history;

    logic [IW-1:0]      e_c;
    logic               press_c;
    logic               timeout_c;
    logic               correct_c;
    logic               strike_c;
    logic               last_round_c;
    logic               out_of_lives_c;
    logic [STRK_W-1:0]  strikes_inc_c;
    logic [SW1-1:0]     score_sum_c;
    logic [SCORE_W-1:0] score_sat_c;

    defuse_rule_lut #(
        .N_SW     (N_SW),
        .N_ROUNDS (N_ROUNDS),
        .IW       (IW)
    ) u_rule_lut (
        .r       (round_idx),
        .main    (main_disp),
        .subs    (sub_disp),
        .history (history),
        .e_c     (e_c)
    );

    generate
        if (ROUND_TICKS == 0) begin : g_no_timeout
            assign timeout_c = 1'b0;
        end else begin : g_timeout
            assign timeout_c = tick && (tick_cnt == TW'(ROUND_TICKS - 1));
        end
    endgenerate

    // A press beats a coincident final tick, so the press decides the strike.
    assign press_c        = button & ~btn_q;
    assign correct_c      = (switch_position == (N_SW'(1) << e_c));
    assign strike_c       = press_c ? ~correct_c : timeout_c;
    assign last_round_c   = (round_idx == RIDX_W'(N_ROUNDS - 1));
    assign strikes_inc_c  = strikes + STRK_W'(1);
    assign out_of_lives_c = (strikes_inc_c >= STRK_W'(N_LIVES));
    assign score_sum_c    = SW1'(Score) + SW1'(PTS);
    assign score_sat_c    = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= S_IDLE;
            btn_q         <= 1'b0;
            rearm         <= 1'b1;
            tick_cnt      <= '0;
            history       <= '0;
            rnd.rnd_req   <= 1'b0;
            main_disp     <= '0;
            sub_disp      <= '0;
            round_idx     <= '0;
            strikes       <= '0;
            Score         <= '0;
            Game_Complete <= 1'b0;
            game_won      <= 1'b0;
        end else begin
            btn_q         <= button;
            rnd.rnd_req   <= 1'b0;
            Game_Complete <= 1'b0;
            if (!Game_Enable) begin
                rearm <= 1'b1;
            end

            // Dropping the enable abandons the game silently, keeping the score.
            if (state != S_IDLE && !Game_Enable) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (Game_Enable && rearm) begin
                            rearm       <= 1'b0;
                            Score       <= '0;
                            round_idx   <= '0;
                            strikes     <= '0;
                            game_won    <= 1'b0;
                            rnd.rnd_req <= 1'b1;
                            state       <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        state <= S_WAIT_RND;
                    end
                    S_WAIT_RND: begin
                        if (rnd.rnd_valid) begin
                            main_disp <= rnd.rnd_main;
                            sub_disp  <= rnd.rnd_subs;
                            tick_cnt  <= '0;
                            state     <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (press_c && correct_c) begin
                            for (int i = 0; i < int'(N_ROUNDS); i++) begin
                                if (round_idx == RIDX_W'(i)) begin
                                    history[i] <= e_c;
                                end
                            end
                            Score <= score_sat_c;
                            if (last_round_c) begin
                                Game_Complete <= 1'b1;
                                game_won      <= 1'b1;
                                state         <= S_WIN;
                            end else begin
                                round_idx   <= round_idx + RIDX_W'(1);
                                rnd.rnd_req <= 1'b1;
                                state       <= S_REQ;
                            end
                        end else if (strike_c) begin
                            strikes <= strikes_inc_c;
                            if (out_of_lives_c) begin
                                Game_Complete <= 1'b1;
                                game_won      <= 1'b0;
                                state         <= S_LOSS;
                            end else begin
                                rnd.rnd_req <= 1'b1;
                                state       <= S_REQ;
                            end
                        end else if (tick) begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    S_WIN, S_LOSS: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
